alu_result_uart_tx: RTL
=======================

ALU_RESULT_UART_TX -- requirements
Module: alu_result_uart_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit (>=2).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  ALU result word present.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a word.
REQ-007 SHALL have port in_result  input  8  ALU 8-bit result.
REQ-008 SHALL have port in_carry  input  1  ALU carry flag.
REQ-009 SHALL have port in_ovf  input  1  ALU overflow flag.
REQ-010 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port frame_cnt  output  8  completed-frame counter.

Function
REQ-014 SHALL accept a 10-bit word {in_ovf, in_carry, in_result} on a rising edge with in_valid && in_ready.
REQ-015 SHALL drive in_ready = (level < DEPTH) combinationally; no bypass when full, even if a pop occurs in the same cycle.
REQ-016 SHALL, on simultaneous push and pop, leave level unchanged; push-only +1, pop-only -1.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL pop in IDLE when level>0: load shifter, go START, tx<=0 on the same edge (first tx low one edge after the accepting push edge into an empty idle block).
REQ-019 SHALL hold each bit exactly CLKS_PER_BIT cycles via a bit-timer that reloads per bit.
REQ-020 SHALL send frame order: start(0), in_result[0..7] LSB first, carry, ovf, parity, stop(1): 13 bits, 13*CLKS_PER_BIT cycles.
REQ-021 SHALL compute parity as even parity (XOR) over the 10 data bits.
REQ-022 SHALL, at the end of STOP, pop and go to START on that same edge if level>0 (no idle gap), else go IDLE with tx=1.
REQ-023 SHALL increment frame_cnt on the final edge of each STOP bit, wrapping 255->0.
REQ-024 SHALL keep FIFO contents and order unaffected by in_valid while full; in_result/flags are don't-care when in_valid=0.

Reset
REQ-025 SHALL, on rst_n low (asynchronously, including mid-frame), force tx=1, busy=0, state IDLE, level=0 (FIFO emptied), frame_cnt=0, bit-timer and shifter 0.
REQ-026 SHALL drive in_ready=1 during and immediately after reset.

Verification (DEPTH=4, CLKS_PER_BIT=4)
REQ-027 SHALL check single word 0x4B, carry=1, ovf=0 -> tx bits 0,1,1,0,1,0,0,1,0,1,0,1,1 each 4 cycles (52 total), frame_cnt 0->1, busy falls after stop.
REQ-028 SHALL check parity edges: 0x00/c0/o0 -> parity 0; 0xFF/c1/o1 -> parity 0; 0x01/c0/o0 -> parity 1.
REQ-029 SHALL check in_valid held high with 6 distinct words -> 5 accepted (1 popped + 4 stored), in_ready low until first frame ends, then 6th accepted; all 6 frames contiguous, in order, 312 cycles, busy never low between.
REQ-030 SHALL check full FIFO with pop on the same edge -> in_ready low that cycle, level 4->3, no word lost or duplicated.
REQ-031 SHALL check rst_n asserted mid-DATA of frame 2 with 3 words queued -> tx=1 immediately, level=0, frame_cnt=0; new word after release sends cleanly.
REQ-032 SHALL check 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/alu_result_uart_tx.sv
// Buffers ALU result words {ovf, carry, result} in a small FIFO and serialises
// each as a 13-bit UART frame: start, 8 result bits LSB first, carry, ovf, even parity, stop.
module alu_result_uart_tx #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_result,
  input  logic                    in_carry,
  input  logic                    in_ovf,
  output logic                    tx,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              frame_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [10:0]     shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [AW:0]     level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [9:0]      mem_q [DEPTH];
  logic [9:0]      mem_d [DEPTH];

  logic            push;
  logic            pop;
  logic            bit_done;
  logic [9:0]      head;

  assign in_ready  = (level_q < FULL);
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign bit_done  = (timer_q == BIT_LAST);

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign level     = level_q;
  assign frame_cnt = frame_cnt_q;

  // Shifter holds {parity, ovf, carry, result}; bit 0 is always the next bit to send.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;

    if (state_q != IDLE) begin
      timer_d = bit_done ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = {^head, head};
          timer_d = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 4'd9) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = {^head, head};
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_ovf, in_carry, in_result};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      frame_cnt_q <= '0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      frame_cnt_q <= frame_cnt_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

endmodule
